// File: rtl/pmu_ahb_arb_pkg.sv
// Shared types and AHB-lite encodings for the pmu_ahb requester arbiter.
package pmu_ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - index with highest priority this round
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             found;
    logic [PTR_W-1:0] k;

    // Scan from ptr upward, wrapping at N_REQ; first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = PTR_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = k;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmu_ahb_arbiter.sv
// Shares the pmu_ahb AHB-lite slave port between N_REQ requesters.
// Round-robin grant, one single-word NONSEQ transfer in flight, data-phase watchdog.
// Ports:
//   clk_i, rst_i                        - clock, async active-high reset
//   req_i/we_i/addr_i/wdata_i           - per-requester request, held until ack_o
//   ack_o/err_o/rdata_o                 - completion pulse, error flag, read data
//   hsel_o/haddr_o/hwrite_o/htrans_o    - AHB address phase
//   hsize_o/hburst_o                    - fixed word / SINGLE
//   hwdata_o                            - AHB write data (data phase)
//   hready_i/hresp_i/hrdata_i           - AHB slave response
module pmu_ahb_arbiter
    import pmu_ahb_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            we_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic                        err_o,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        hsel_o,
    output logic [DATA_WIDTH-1:0]       haddr_o,
    output logic                        hwrite_o,
    output logic [1:0]                  htrans_o,
    output logic [2:0]                  hsize_o,
    output logic [2:0]                  hburst_o,
    output logic [DATA_WIDTH-1:0]       hwdata_o,
    input  logic                        hready_i,
    input  logic [1:0]                  hresp_i,
    input  logic [DATA_WIDTH-1:0]       hrdata_i
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [WD_W-1:0]         wd_q, wd_d;

    logic [N_REQ-1:0]        grant;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        rr_next;
    logic [N_REQ-1:0]        ack_vec;
    logic                    wd_expired;
    logic                    unused_hresp;

    assign unused_hresp = hresp_i[1];
    assign hsize_o      = HSIZE_WORD;
    assign hburst_o     = HBURST_SINGLE;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req_i),
        .ptr       (rr_q),
        .grant     (grant),
        .grant_idx (gnt_idx)
    );

    assign rr_next    = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
    assign ack_vec    = N_REQ'(1) << idx_q;
    // Abort in the cycle whose increment would make the count reach TIMEOUT_CYCLES,
    // so the counter stops at TIMEOUT_CYCLES-1 and can never wrap.
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // State and transfer latches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end

    // Next state, bus drive and completion; ack/err/rdata follow hready_i in DATA
    // so the requester sees completion in the same cycle the slave finishes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rr_d     = rr_q;
        wd_d     = wd_q;
        hsel_o   = 1'b0;
        htrans_o = HTRANS_IDLE;
        haddr_o  = '0;
        hwrite_o = 1'b0;
        hwdata_o = '0;
        ack_o    = '0;
        err_o    = 1'b0;
        rdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    idx_d   = gnt_idx;
                    we_d    = we_i[gnt_idx];
                    addr_d  = addr_i[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
                    wdata_d = wdata_i[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                hsel_o   = 1'b1;
                htrans_o = HTRANS_NONSEQ;
                haddr_o  = addr_q;
                hwrite_o = we_q;
                if (hready_i) begin
                    wd_d    = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                hwdata_o = wdata_q;
                if (hready_i) begin
                    ack_o   = ack_vec;
                    err_o   = hresp_i[0];
                    rdata_o = we_q ? '0 : hrdata_i;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    ack_o   = ack_vec;
                    err_o   = 1'b1;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmu_ahb_arbiter.sv
// Bench for pmu_ahb_arbiter: scoreboard of expected completions plus a small AHB slave model.
module tb_pmu_ahb_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N-1:0]    we_i;
    logic [N*DW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    ack_o;
    logic            err_o;
    logic [DW-1:0]   rdata_o;
    logic            hsel_o;
    logic [DW-1:0]   haddr_o;
    logic            hwrite_o;
    logic [1:0]      htrans_o;
    logic [2:0]      hsize_o;
    logic [2:0]      hburst_o;
    logic [DW-1:0]   hwdata_o;
    logic            hready_i;
    logic [1:0]      hresp_i;
    logic [DW-1:0]   hrdata_i;

    pmu_ahb_arbiter #(
        .N_REQ          (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .hsel_o   (hsel_o),
        .haddr_o  (haddr_o),
        .hwrite_o (hwrite_o),
        .htrans_o (htrans_o),
        .hsize_o  (hsize_o),
        .hburst_o (hburst_o),
        .hwdata_o (hwdata_o),
        .hready_i (hready_i),
        .hresp_i  (hresp_i),
        .hrdata_i (hrdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave model: configurable wait states, two-cycle ERROR, or hang.
    int            slv_wait  = 0;
    bit            slv_err   = 1'b0;
    bit            slv_hang  = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    logic          in_dp;
    int            wcnt;
    logic [DW-1:0] slv_haddr;
    logic          slv_hwrite;

    assign hready_i = !in_dp || (wcnt == 0 && !slv_hang);
    assign hresp_i  = (in_dp && slv_err && wcnt <= 1) ? 2'b01 : 2'b00;
    assign hrdata_i = (in_dp && wcnt == 0 && !slv_hang) ? slv_rdata : 32'h5a5a5a5a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_dp      <= 1'b0;
            wcnt       <= 0;
            slv_haddr  <= '0;
            slv_hwrite <= 1'b0;
        end else begin
            if (in_dp) begin
                if (hready_i) in_dp <= 1'b0;
                else if (wcnt > 0) wcnt <= wcnt - 1;
            end
            if (hsel_o && htrans_o == 2'b10 && hready_i) begin
                in_dp      <= 1'b1;
                wcnt       <= slv_wait;
                slv_haddr  <= haddr_o;
                slv_hwrite <= hwrite_o;
            end
        end
    end

    typedef struct {
        int            idx;
        logic          err;
        logic [DW-1:0] rdata;
        logic [DW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            lat;
        int            gap;
        int            drv;
    } exp_t;

    exp_t sb[$];
    exp_t r;
    int   last_ack = 0;

    // Completion monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_onehot", 64'($countones(ack_o) <= 1), 64'(1));
            if (ack_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 64'(ack_o), 64'(0));
                end else begin
                    r = sb.pop_front();
                    chk("ack_vec", 64'(ack_o), 64'(1) << r.idx);
                    chk("err", 64'(err_o), 64'(r.err));
                    chk("rdata", 64'(rdata_o), 64'(r.rdata));
                    chk("haddr", 64'(slv_haddr), 64'(r.addr));
                    chk("hwrite", 64'(slv_hwrite), 64'(r.we));
                    if (r.we) chk("hwdata", 64'(hwdata_o), 64'(r.wdata));
                    if (r.lat >= 0) chk("latency", 64'(cyc - r.drv), 64'(r.lat));
                    if (r.gap > 0) chk("ack_gap", 64'(cyc - last_ack), 64'(r.gap));
                end
                last_ack = cyc;
            end else begin
                chk("idle_quiet", 64'({err_o, rdata_o}), 64'(0));
            end
        end
    end

    task automatic set_req(input int k, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
        we_i[k]               = we;
        addr_i[k*DW +: DW]    = a;
        wdata_i[k*DW +: DW]   = d;
        req_i[k]              = 1'b1;
    endtask

    task automatic push(input int k, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic e, input logic [DW-1:0] rd, input int lat, input int gap);
        exp_t x;
        x.idx = k; x.we = we; x.addr = a; x.wdata = d;
        x.err = e; x.rdata = rd; x.lat = lat; x.gap = gap; x.drv = cyc;
        sb.push_back(x);
    endtask

    task automatic wait_ack(input int k, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (ack_o[k]) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk("ack_timeout", 64'(0), 64'(1));
        if (drop) req_i[k] = 1'b0;
    endtask

    task automatic do_xfer(input int k, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d,
                           input int wt, input bit se, input logic [DW-1:0] srd, input bit hang,
                           input logic e, input logic [DW-1:0] rd, input int lat);
        @(negedge clk);
        slv_wait = wt; slv_err = se; slv_rdata = srd; slv_hang = hang;
        set_req(k, we, a, d);
        push(k, we, a, d, e, rd, lat, 0);
        wait_ack(k, 1'b1);
        if (hang) begin
            @(posedge clk);
            #1 slv_hang = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_htrans", 64'(htrans_o), 64'(0));
        chk("rst_hsel",   64'(hsel_o),   64'(0));
        chk("rst_haddr",  64'(haddr_o),  64'(0));
        chk("rst_hwrite", 64'(hwrite_o), 64'(0));
        chk("rst_hwdata", 64'(hwdata_o), 64'(0));
        chk("rst_ack",    64'(ack_o),    64'(0));
        chk("rst_err",    64'(err_o),    64'(0));
        chk("rst_rdata",  64'(rdata_o),  64'(0));
        rst = 1'b0;

        // Simultaneous held requests: order 0,1,0,1, three cycles apart
        @(negedge clk);
        slv_wait = 0; slv_err = 1'b0; slv_hang = 1'b0; slv_rdata = 32'hfeedf00d;
        set_req(0, 1'b1, 32'h80100010, 32'h11110000);
        set_req(1, 1'b1, 32'h80100020, 32'h22220000);
        push(0, 1'b1, 32'h80100010, 32'h11110000, 1'b0, '0, 2, 0);
        push(1, 1'b1, 32'h80100020, 32'h22220000, 1'b0, '0, -1, 3);
        push(0, 1'b1, 32'h80100010, 32'h11110000, 1'b0, '0, -1, 3);
        push(1, 1'b1, 32'h80100020, 32'h22220000, 1'b0, '0, -1, 3);
        wait_ack(0, 1'b0);
        wait_ack(1, 1'b0);
        wait_ack(0, 1'b0);
        wait_ack(1, 1'b0);
        req_i = '0;

        // Single write with cycle-by-cycle bus checks
        @(negedge clk);
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hfeedf00d;
        set_req(0, 1'b1, 32'h80100000, 32'h1);
        push(0, 1'b1, 32'h80100000, 32'h1, 1'b0, '0, 2, 0);
        chk("t1_idle_htrans", 64'(htrans_o), 64'(0));
        @(negedge clk);
        chk("t1_nonseq", 64'(htrans_o), 64'(2'b10));
        chk("t1_hsel",   64'(hsel_o),   64'(1));
        chk("t1_haddr",  64'(haddr_o),  64'(32'h80100000));
        chk("t1_hwrite", 64'(hwrite_o), 64'(1));
        chk("t1_hsize",  64'(hsize_o),  64'(3'b010));
        chk("t1_hburst", 64'(hburst_o), 64'(3'b000));
        @(negedge clk);
        chk("t1_data_htrans", 64'(htrans_o), 64'(0));
        chk("t1_data_hsel",   64'(hsel_o),   64'(0));
        chk("t1_hwdata",      64'(hwdata_o), 64'(1));
        wait_ack(0, 1'b1);

        // Read with two wait states
        do_xfer(1, 1'b0, 32'h801000ac, '0, 2, 1'b0, 32'hcafecafe, 1'b0, 1'b0, 32'hcafecafe, 4);
        // Two-cycle ERROR response on a write
        do_xfer(0, 1'b1, 32'h80100040, 32'hdeadbeef, 1, 1'b1, 32'hfeedf00d, 1'b0, 1'b1, '0, 3);
        // Hung slave: abort on the 8th data-phase cycle
        do_xfer(1, 1'b0, 32'h80100080, '0, 0, 1'b0, 32'h13572468, 1'b1, 1'b1, '0, 9);
        // Normal service after the timeout
        do_xfer(0, 1'b0, 32'h80100084, '0, 1, 1'b0, 32'h0badc0de, 1'b0, 1'b0, 32'h0badc0de, 3);

        // Reset during ADDR with rr pointer at 1; afterwards requester 0 must win first
        @(negedge clk);
        slv_wait = 0; slv_err = 1'b0; slv_hang = 1'b0; slv_rdata = 32'h31415926;
        set_req(0, 1'b1, 32'h801000f0, 32'haaaa5555);
        set_req(1, 1'b0, 32'h801000f4, '0);
        @(posedge clk);
        #1 chk("t6_in_addr", 64'(htrans_o), 64'(2'b10));
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_htrans", 64'(htrans_o), 64'(0));
        chk("t6_hsel",   64'(hsel_o),   64'(0));
        chk("t6_ack",    64'(ack_o),    64'(0));
        rst = 1'b0;
        push(0, 1'b1, 32'h801000f0, 32'haaaa5555, 1'b0, '0, 2, 0);
        push(1, 1'b0, 32'h801000f4, '0, 1'b0, 32'h31415926, -1, 3);
        wait_ack(0, 1'b1);
        wait_ack(1, 1'b1);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
